button_command_scheduler: RTL

Converts the four debounced button levels into a single stream of discrete game commands for the racer control logic. Sits between `buttons_debouncer` and the game FSM. It detects presses, generates typematic auto-repeat while a button is held, and arbitrates simultaneous events round-robin. Commands are delivered through a one-entry valid/ready output slot.

---
 rtl/button_command_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/button_command_scheduler.sv
// button_command_scheduler
// Turns the four debounced button levels into a stream of discrete game
// commands. Detects presses, generates typematic auto-repeat while a button
// is held, merges events per button, and arbitrates round-robin into a
// one-entry valid/ready output slot.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   btnR_D      debounced right button level (cmd 0)
//   btnL_D      debounced left button level  (cmd 1)
//   btnD_D      debounced down button level  (cmd 2)
//   btnU_D      debounced up button level    (cmd 3)
//   cmd_valid   output slot holds a command
//   cmd_ready   consumer accepts the command this cycle
//   cmd         command code
//   cmd_repeat  1 = auto-repeat, 0 = initial press
//   overrun     one-cycle pulse when an event merged into a pending one
module button_command_scheduler #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnR_D,
  input  logic       btnL_D,
  input  logic       btnD_D,
  input  logic       btnU_D,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd,
  output logic       cmd_repeat,
  output logic       overrun
);

  localparam int MAX_CNT  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW       = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam int DLY_LD_I = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int PER_LD_I = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;
  localparam logic [CW-1:0] DLY_LD = CW'(DLY_LD_I);
  localparam logic [CW-1:0] PER_LD = CW'(PER_LD_I);
  localparam logic RPT_EN = (REPEAT_DELAY != 0);

  logic [3:0]    level;
  logic [3:0]    prev;
  logic [3:0]    armed;
  logic [3:0]    pend;
  logic [3:0]    rep;
  logic [CW-1:0] cnt [4];
  logic [1:0]    last;

  logic [3:0]    press_ev;
  logic [3:0]    rpt_ev;
  logic [3:0]    evt;
  logic          slot_free;
  logic          gnt_valid;
  logic [1:0]    gnt_idx;
  logic [3:0]    gnt_mask;
  logic [3:0]    pend_eff;
  logic [3:0]    pend_nxt;
  logic [3:0]    rep_nxt;
  logic          ovr_nxt;
  logic [CW-1:0] cnt_nxt [4];
  logic [1:0]    idx;

  assign level = {btnU_D, btnD_D, btnL_D, btnR_D};

  always_comb begin
    press_ev  = level & ~prev;
    rpt_ev    = '0;
    slot_free = ~cmd_valid | cmd_ready;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    ovr_nxt   = 1'b0;

    // armed blocks repeats for a button that was already held through reset
    for (int i = 0; i < 4; i++) begin
      rpt_ev[i] = level[i] & prev[i] & armed[i] & RPT_EN & (cnt[i] == '0);
    end
    evt = press_ev | rpt_ev;

    // round-robin search starting just after the last granted button
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!gnt_valid && pend[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end

    gnt_mask = (slot_free && gnt_valid) ? 4'(4'b0001 << gnt_idx) : 4'b0000;

    // a new event on the button being granted re-sets pend without overrun
    pend_eff = pend & ~gnt_mask;
    pend_nxt = pend_eff;
    rep_nxt  = rep;
    for (int i = 0; i < 4; i++) begin
      if (evt[i]) begin
        if (pend_eff[i]) begin
          rep_nxt[i] = rep[i] & rpt_ev[i];
          ovr_nxt    = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
          rep_nxt[i]  = rpt_ev[i];
        end
      end
    end

    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (press_ev[i]) begin
        cnt_nxt[i] = DLY_LD;
      end else if (rpt_ev[i]) begin
        cnt_nxt[i] = PER_LD;
      end else if (level[i] && prev[i] && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= level;
      armed      <= '0;
      pend       <= '0;
      rep        <= '0;
      last       <= 2'd3;
      cmd_valid  <= 1'b0;
      cmd        <= 2'd0;
      cmd_repeat <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      prev    <= level;
      armed   <= armed | press_ev;
      pend    <= pend_nxt;
      rep     <= rep_nxt;
      overrun <= ovr_nxt;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (slot_free) begin
        if (gnt_valid) begin
          cmd_valid  <= 1'b1;
          cmd        <= gnt_idx;
          cmd_repeat <= rep[gnt_idx];
          last       <= gnt_idx;
        end else begin
          cmd_valid  <= 1'b0;
        end
      end
    end
  end

endmodule
